// File: rtl/ready_latch_np.sv
// Player-ready synchroniser: a free-running modulo counter is frozen onto NUM
// the moment the last of PLAYERS ready buttons arms; OK releases or cancels.
module ready_latch_np #(
    parameter int TICK_DIV = 5_000_000,
    parameter int NUM_MOD  = 10,
    parameter int NUM_W    = 4,
    parameter int PLAYERS  = 2,
    parameter int MODE     = 0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [PLAYERS-1:0] READY,
    input  logic               OK,
    output logic [NUM_W-1:0]   NUM,
    output logic               VALID,
    output logic [PLAYERS-1:0] ARMED,
    output logic               TICK
);

    localparam logic [NUM_W-1:0] CNT_LAST = NUM_W'(NUM_MOD - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMING  = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PLAYERS-1:0] ready_q, ready_d;
    logic [PLAYERS-1:0] armed_q, armed_d;
    logic [PLAYERS-1:0] rise;
    logic [PLAYERS-1:0] armed_or_rise;
    logic               ok_q, ok_d;
    logic               ok_rise;
    logic               all_ready;
    logic               step;
    logic [NUM_W-1:0]   cnt_q, cnt_d;
    logic [NUM_W-1:0]   num_q, num_d;
    logic               valid_q, valid_d;

    // Registered copies reset high so a button held through reset is not an edge.
    for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_edge
        assign rise[gi]          = READY[gi] & ~ready_q[gi];
        assign armed_or_rise[gi] = armed_q[gi] | rise[gi];
    end

    assign ok_rise   = OK & ~ok_q;
    assign all_ready = &armed_or_rise;
    assign ready_d   = READY;
    assign ok_d      = OK;

    if (MODE == 0) begin : g_tick_div
        localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
        localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

        logic [DIV_W-1:0] div_q, div_d;
        logic             div_wrap;

        assign div_wrap = (div_q == DIV_LAST);

        always_comb begin
            div_d = div_q + 1'b1;
            if (div_wrap) begin
                div_d = '0;
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                div_q <= '0;
            end else begin
                div_q <= div_d;
            end
        end

        assign step = div_wrap;
        assign TICK = div_wrap;
    end else begin : g_tick_every
        assign step = 1'b1;
        assign TICK = 1'b1;
    end

    // The counter keeps running in every state, including while locked.
    always_comb begin
        cnt_d = cnt_q;
        if (step) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        num_d   = num_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE, S_ARMING: begin
                if (ok_rise) begin
                    // Cancel beats a simultaneous completing press.
                    armed_d = '0;
                    state_d = S_IDLE;
                end else if (all_ready) begin
                    num_d   = cnt_q;
                    valid_d = 1'b1;
                    armed_d = '1;
                    state_d = S_LOCKED;
                end else begin
                    armed_d = armed_or_rise;
                    state_d = (|armed_or_rise) ? S_ARMING : S_IDLE;
                end
            end
            S_LOCKED: begin
                if (ok_rise) begin
                    armed_d = '0;
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                armed_d = '0;
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            ready_q <= '1;
            ok_q    <= 1'b1;
            armed_q <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            ok_q    <= ok_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            valid_q <= valid_d;
        end
    end

    assign NUM   = num_q;
    assign VALID = valid_q;
    assign ARMED = armed_q;

endmodule

// File: tb/tb_ready_latch_np.sv
// Directed bench for ready_latch_np: a divided-tick 2-player instance and an
// every-clock 3-player instance, checked through an expectation queue.
module tb_ready_latch_np;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, ok_a, valid_a, tick_a;
    logic [1:0] ready_a, armed_a;
    logic [3:0] num_a;

    logic       rst_b, ok_b, valid_b, tick_b;
    logic [2:0] ready_b, armed_b;
    logic [2:0] num_b;

    ready_latch_np #(
        .TICK_DIV(4), .NUM_MOD(10), .NUM_W(4), .PLAYERS(2), .MODE(0)
    ) dut_a (
        .CLK(clk), .RST(rst_a), .READY(ready_a), .OK(ok_a),
        .NUM(num_a), .VALID(valid_a), .ARMED(armed_a), .TICK(tick_a)
    );

    ready_latch_np #(
        .TICK_DIV(4), .NUM_MOD(7), .NUM_W(3), .PLAYERS(3), .MODE(1)
    ) dut_b (
        .CLK(clk), .RST(rst_b), .READY(ready_b), .OK(ok_b),
        .NUM(num_b), .VALID(valid_b), .ARMED(armed_b), .TICK(tick_b)
    );

    typedef struct {
        string      tag;
        logic       sel;
        logic [3:0] num;
        logic       valid;
        logic [2:0] armed;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   n_a = 0;
    int   n_b = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        exp_t e;
        logic ra, rb;
        ra = rst_a;
        rb = rst_b;
        @(posedge clk);
        #1;
        n_a = ra ? 0 : n_a + 1;
        n_b = rb ? 0 : n_b + 1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel == 1'b0) begin
                chk({e.tag, "_num"},   32'(num_a),   32'(e.num));
                chk({e.tag, "_valid"}, 32'(valid_a), 32'(e.valid));
                chk({e.tag, "_armed"}, 32'(armed_a), 32'(e.armed[1:0]));
            end else begin
                chk({e.tag, "_num"},   32'(num_b),   32'(e.num));
                chk({e.tag, "_valid"}, 32'(valid_b), 32'(e.valid));
                chk({e.tag, "_armed"}, 32'(armed_b), 32'(e.armed));
            end
            $display("txn %s: A num=%0d valid=%0b armed=%b | B num=%0d valid=%0b armed=%b",
                     e.tag, num_a, valid_a, armed_a, num_b, valid_b, armed_b);
        end
    endtask

    task automatic cyc_a(input logic [1:0] rdy, input logic okv, input logic [3:0] en,
                         input logic ev, input logic [1:0] ea, input string tag);
        exp_t e;
        ready_a = rdy;
        ok_a    = okv;
        e.tag = tag; e.sel = 1'b0; e.num = en; e.valid = ev; e.armed = {1'b0, ea};
        sb.push_back(e);
        step();
    endtask

    task automatic cyc_b(input logic [2:0] rdy, input logic okv, input logic [3:0] en,
                         input logic ev, input logic [2:0] ea, input string tag);
        exp_t e;
        ready_b = rdy;
        ok_b    = okv;
        e.tag = tag; e.sel = 1'b1; e.num = en; e.valid = ev; e.armed = ea;
        sb.push_back(e);
        step();
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ready_a = '0; ready_b = '0; ok_a = 1'b0; ok_b = 1'b0;

        // Reset state and divider/counter walk.
        cyc_a(2'b00, 1'b0, 4'd0, 1'b0, 2'b00, "a_rst");
        cyc_a(2'b00, 1'b0, 4'd0, 1'b0, 2'b00, "a_rst");
        chk("a_rst_tick", 32'(tick_a), 32'd0);
        rst_a = 1'b0;
        for (int i = 1; i <= 44; i++) begin
            cyc_a(2'b00, 1'b0, 4'd0, 1'b0, 2'b00, "a_idle");
            chk("a_tick", 32'(tick_a), 32'(n_a % 4 == 3));
        end
        // cnt reached 1 after 44 cycles (wrapped past 9).
        cyc_a(2'b11, 1'b0, 4'd1, 1'b1, 2'b11, "a_latch44");

        // Reset while locked, then the two-player round.
        rst_a = 1'b1;
        cyc_a(2'b00, 1'b0, 4'd0, 1'b0, 2'b00, "a_rst_locked");
        cyc_a(2'b00, 1'b0, 4'd0, 1'b0, 2'b00, "a_rst");
        rst_a = 1'b0;
        for (int i = 1; i <= 9; i++) cyc_a(2'b00, 1'b0, 4'd0, 1'b0, 2'b00, "a_wait");
        cyc_a(2'b01, 1'b0, 4'd0, 1'b0, 2'b01, "a_p0");
        for (int i = 11; i <= 20; i++) cyc_a(2'b01, 1'b0, 4'd0, 1'b0, 2'b01, "a_p0_held");
        cyc_a(2'b11, 1'b0, 4'd5, 1'b1, 2'b11, "a_latch21");
        for (int i = 22; i <= 30; i++) cyc_a(2'b11, 1'b0, 4'd5, 1'b1, 2'b11, "a_hold");
        cyc_a(2'b00, 1'b0, 4'd5, 1'b1, 2'b11, "a_release_btn");
        cyc_a(2'b01, 1'b0, 4'd5, 1'b1, 2'b11, "a_locked_rise");
        cyc_a(2'b00, 1'b1, 4'd5, 1'b0, 2'b00, "a_ok_release");
        cyc_a(2'b00, 1'b0, 4'd5, 1'b0, 2'b00, "a_idle_after_ok");
        cyc_a(2'b11, 1'b0, 4'd8, 1'b1, 2'b11, "a_both_latch");

        // OK release, re-arm one player, then cancel against the completing press.
        cyc_a(2'b00, 1'b1, 4'd8, 1'b0, 2'b00, "a_ok2");
        cyc_a(2'b01, 1'b0, 4'd8, 1'b0, 2'b01, "a_arm_p0");
        cyc_a(2'b11, 1'b1, 4'd8, 1'b0, 2'b00, "a_cancel_wins");
        cyc_a(2'b00, 1'b0, 4'd8, 1'b0, 2'b00, "a_after_cancel");
        cyc_a(2'b10, 1'b0, 4'd8, 1'b0, 2'b10, "a_arm_p1");
        cyc_a(2'b10, 1'b0, 4'd8, 1'b0, 2'b10, "a_p1_held");
        cyc_a(2'b11, 1'b0, 4'd0, 1'b1, 2'b11, "a_wrap_latch");

        // Buttons held through reset must not arm.
        rst_a = 1'b1;
        cyc_a(2'b11, 1'b0, 4'd0, 1'b0, 2'b00, "a_rst_held");
        cyc_a(2'b11, 1'b0, 4'd0, 1'b0, 2'b00, "a_rst_held");
        rst_a = 1'b0;
        for (int i = 1; i <= 3; i++) cyc_a(2'b11, 1'b0, 4'd0, 1'b0, 2'b00, "a_held_no_arm");
        cyc_a(2'b00, 1'b0, 4'd0, 1'b0, 2'b00, "a_held_release");
        cyc_a(2'b11, 1'b0, 4'd1, 1'b1, 2'b11, "a_repress_latch");

        // Every-clock counter, 3 players: latch after j cycles captures j mod 7.
        for (int j = 1; j <= 14; j++) begin
            rst_b = 1'b1;
            cyc_b(3'b000, 1'b0, 4'd0, 1'b0, 3'b000, "b_rst");
            rst_b = 1'b0;
            for (int k = 1; k < j; k++) begin
                cyc_b(3'b000, 1'b0, 4'd0, 1'b0, 3'b000, "b_wait");
                chk("b_tick", 32'(tick_b), 32'd1);
            end
            if (j >= 3 && (j % 2) == 1) begin
                cyc_b(3'b001, 1'b0, 4'd0, 1'b0, 3'b001, "b_pre_arm");
            end else begin
                cyc_b(3'b000, 1'b0, 4'd0, 1'b0, 3'b000, "b_wait");
            end
            cyc_b(3'b111, 1'b0, 4'(j % 7), 1'b1, 3'b111, "b_latch");
            cyc_b(3'b111, 1'b0, 4'(j % 7), 1'b1, 3'b111, "b_hold");
        end
        rst_b = 1'b1;
        cyc_b(3'b000, 1'b0, 4'd0, 1'b0, 3'b000, "b_rst_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ready_latch_np.md
# ready_latch_np

Parametrised player-ready synchroniser and start-number latch for the factorization game front end. A free-running modulo counter advances on a divided tick or on every clock. Each player arms by pressing READY, and the moment the last player arms, the current counter value is frozen onto NUM with VALID raised. An OK press releases the lock (or cancels arming) for the next round. It generalises the single-pair, fixed-divider ready latch to N players, configurable divider, modulus and advance mode, with a proper arm/lock/release state machine.

## Interface
- TICK_DIV, 5_000_000: clock cycles per counter step in MODE 0; legal range ≥1.
- NUM_MOD, 10: counter modulus; counter range 0..NUM_MOD-1; requires 2 ≤ NUM_MOD ≤ 2**NUM_W.
- NUM_W, 4: width of NUM.
- PLAYERS, 2: number of READY inputs; legal range ≥1.
- MODE, 0: 0 = counter advances on divider tick; 1 = counter advances every clock.
- CLK  input  1  system clock; all logic on its rising edge.
- RST  input  1  synchronous, active-high reset.
- READY  input  PLAYERS  per-player ready buttons; level, already debounced and synchronous to CLK.
- OK  input  1  release/cancel button; level, debounced, synchronous.
- NUM  output  NUM_W  latched start number.
- VALID  output  1  high while in LOCKED.
- ARMED  output  PLAYERS  sticky per-player ready flags.
- TICK  output  1  one-cycle pulse on each divider wrap (MODE 0); constant 1 in MODE 1.

## Operation
- Edge detect: READY_q and OK_q are one-cycle registered copies. rise[i] = READY[i] & ~READY_q[i]; ok_rise = OK & ~OK_q.
- Divider: div counts 0..TICK_DIV-1 and wraps to 0. TICK = (div == TICK_DIV-1).
- Counter cnt: advances when (MODE==0 ? TICK : 1). It wraps from NUM_MOD-1 to 0 and runs in every state, including LOCKED.
- States:
  - IDLE: no flags set.
  - ARMING: at least one flag set, not all.
  - LOCKED: number captured.
- Define all_ready = &(ARMED | rise).
- IDLE/ARMING, evaluated in this priority order:
  1. ok_rise: ARMED <= 0; go to IDLE; no latch (cancel).
  2. else if all_ready: NUM <= cnt (value before this edge); VALID <= 1; ARMED <= all ones; go to LOCKED.
  3. else: ARMED <= ARMED | rise; go to ARMING if any flag is set, else IDLE.
- LOCKED:
  - rise is ignored. NUM is held.
  - ok_rise: ARMED <= 0; VALID <= 0; go to IDLE. NUM keeps its last value.
- PLAYERS=1: the first rise from IDLE latches directly, with no visible ARMING.
- A held button never re-arms. The player must release and re-press.

## Timing
- Reset values: NUM=0, VALID=0, ARMED=0, state IDLE, div=0, cnt=0, READY_q=all ones, OK_q=1.
  - Because the _q registers reset high, a button held through reset produces no edge until it is released and re-pressed.
- Reset mid-round, including in LOCKED, returns to the reset values on the next edge. RST overrides all other inputs.
- Latency:
  - A READY edge sampled at edge k sets ARMED[i] at edge k; it is visible after k.
  - On the final arming edge, NUM and VALID update on that same edge (0 cycles beyond the registered edge).
  - ok_rise clears VALID on the edge where it is sampled.
- Simultaneous events:
  - Several players rising on one edge all arm together. If that completes the set, the latch happens on that edge.
  - ok_rise and the final rise on the same edge: cancel wins; no latch.
  - ok_rise and any rise in LOCKED: release only; the rises are discarded.
- Captured value: NUM equals cnt as it was just before the latching edge, even if cnt advances on that same edge.
- TICK is one cycle wide every TICK_DIV cycles. The first TICK is at cycle TICK_DIV-1 after reset release.

## Test plan
- Divider/counter (TICK_DIV=4, NUM_MOD=10, MODE 0), run 44 cycles after reset -> TICK every 4th cycle; cnt walks 0..9, wraps to 0 after 40 cycles, reaches 1 at 44; NUM=0, VALID=0 throughout.
- Two-player latch: P0 press at cycle 10, P1 press at cycle 21 (cnt=5) -> ARMED=01 from cycle 10; at cycle 21 NUM=5, VALID=1, ARMED=11. Counter keeps running while NUM stays 5.
- Cancel and priority: P0 armed, then OK rise and P1 rise on the same edge -> ARMED=00, VALID=0, NUM unchanged, state IDLE.
- Release and replay: in LOCKED, press P0 again -> no change. OK rise -> VALID=0 next edge, NUM holds. A new round with both pressing on one edge latches the current cnt.
- Held-through-reset: READY=11 asserted during and after RST -> no arming. Release both, re-press -> latch.
- MODE 1, NUM_MOD=7, PLAYERS=3, sweep latch cycle 0..13 -> NUM = (latch cycle mod 7) for each; reset in LOCKED -> NUM=0, VALID=0 next edge.
